// File: rtl/mig_app_responder.sv
// mig_app_responder: on-chip stand-in for the MIG user-interface side of the DDR app_* handshake.
// Commands (app_en/app_cmd/app_addr) and write data (app_wdf_*) are accepted independently and
// commit into a 128-bit word array. Reads return after a fixed latency, in order.
// Ports:
//   ui_clk, ui_rst_n                 clock, asynchronous active-low reset
//   app_addr/app_cmd/app_en          command channel (000 write, 001 read, others flagged on cmd_err)
//   app_wdf_data/end/mask/wren       write-data channel (mask bit 1 = byte kept)
//   app_rd_data/_end/_valid          read return, one beat per read
//   app_rdy, app_wdf_rdy             command / write-data ready
//   init_calib_complete              sticky calibration-done flag
//   cmd_err                          sticky protocol error flag
module mig_app_responder #(
    parameter int unsigned ADDR_WIDTH      = 27,
    parameter int unsigned DEPTH_LOG2      = 10,
    parameter int unsigned CALIB_CYCLES    = 16,
    parameter int unsigned READ_LATENCY    = 4,
    parameter int unsigned RDY_STALL_EVERY = 0
) (
    input  logic                  ui_clk,
    input  logic                  ui_rst_n,
    input  logic [ADDR_WIDTH-1:0] app_addr,
    input  logic [2:0]            app_cmd,
    input  logic                  app_en,
    input  logic [127:0]          app_wdf_data,
    input  logic                  app_wdf_end,
    input  logic [15:0]           app_wdf_mask,
    input  logic                  app_wdf_wren,
    output logic [127:0]          app_rd_data,
    output logic                  app_rd_data_end,
    output logic                  app_rd_data_valid,
    output logic                  app_rdy,
    output logic                  app_wdf_rdy,
    output logic                  init_calib_complete,
    output logic                  cmd_err
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CAL_W   = $clog2(CALIB_CYCLES + 1);
    localparam int unsigned STALL_W = (RDY_STALL_EVERY > 1) ? $clog2(RDY_STALL_EVERY) : 1;
    localparam logic [2:0]  CMD_WR  = 3'b000;
    localparam logic [2:0]  CMD_RD  = 3'b001;
    localparam logic [2:0]  MAX_OUT = 3'd4;

    // State
    logic [CAL_W-1:0]      r_cal_cnt;
    logic                  r_calib;
    logic [STALL_W-1:0]    r_stall_cnt;
    logic [127:0]          r_fifo_data [2];
    logic [15:0]           r_fifo_mask [2];
    logic                  r_fifo_wptr;
    logic                  r_fifo_rptr;
    logic [1:0]            r_fifo_cnt;
    logic                  r_wcmd_vld;
    logic [DEPTH_LOG2-1:0] r_wcmd_idx;
    logic [2:0]            r_rd_out;
    logic [READ_LATENCY-1:0] r_rd_vld;
    logic [127:0]          r_rd_pipe [READ_LATENCY];
    logic [127:0]          r_mem [DEPTH];
    logic                  r_app_rdy;
    logic                  r_wdf_rdy;
    logic                  r_rd_valid;
    logic [127:0]          r_rd_data;
    logic                  r_cmd_err;

    // Combinational
    logic                  w_cmd_acc, w_wr_acc, w_rd_acc, w_ill_acc;
    logic                  w_push, w_commit;
    logic [DEPTH_LOG2-1:0] w_addr_idx;
    logic [127:0]          w_merged, w_rd_word;
    logic [CAL_W-1:0]      w_cal_cnt_nxt;
    logic                  w_calib_nxt;
    logic [STALL_W-1:0]    w_stall_cnt_nxt;
    logic                  w_stall_nxt;
    logic [1:0]            w_fifo_cnt_nxt;
    logic                  w_wcmd_vld_nxt;
    logic [2:0]            w_rd_out_nxt;
    logic                  w_unused;

    assign w_unused   = ^app_addr;
    assign w_addr_idx = app_addr[4 +: DEPTH_LOG2];

    // Handshake decode
    assign w_cmd_acc = app_en & r_app_rdy;
    assign w_wr_acc  = w_cmd_acc & (app_cmd == CMD_WR);
    assign w_rd_acc  = w_cmd_acc & (app_cmd == CMD_RD);
    assign w_ill_acc = w_cmd_acc & (app_cmd != CMD_WR) & (app_cmd != CMD_RD);
    assign w_push    = app_wdf_wren & r_wdf_rdy;
    assign w_commit  = r_wcmd_vld & (r_fifo_cnt != 2'd0);

    // Byte-merge of FIFO head into the target word
    always_comb begin
        w_merged = r_mem[r_wcmd_idx];
        for (int b = 0; b < 16; b++) begin
            if (!r_fifo_mask[r_fifo_rptr][b]) begin
                w_merged[8*b +: 8] = r_fifo_data[r_fifo_rptr][8*b +: 8];
            end
        end
    end

    // Read sees a same-cycle commit to the same word
    assign w_rd_word = (w_commit && (r_wcmd_idx == w_addr_idx)) ? w_merged : r_mem[w_addr_idx];

    // Next-state values; ready outputs are registered from these
    assign w_cal_cnt_nxt  = r_calib ? r_cal_cnt : r_cal_cnt + CAL_W'(1);
    assign w_calib_nxt    = r_calib | (r_cal_cnt == CAL_W'(CALIB_CYCLES - 1));
    assign w_fifo_cnt_nxt = r_fifo_cnt + 2'(w_push) - 2'(w_commit);
    assign w_wcmd_vld_nxt = w_wr_acc | (r_wcmd_vld & ~w_commit);
    assign w_rd_out_nxt   = r_rd_out + 3'(w_rd_acc) - 3'(r_rd_vld[READ_LATENCY-1]);

    // Periodic ready stall
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        w_stall_nxt     = 1'b0;
        if (RDY_STALL_EVERY != 0) begin
            w_stall_cnt_nxt = (r_stall_cnt == STALL_W'(RDY_STALL_EVERY - 1)) ? '0
                                                                            : r_stall_cnt + STALL_W'(1);
            w_stall_nxt     = (w_stall_cnt_nxt == STALL_W'(RDY_STALL_EVERY - 1));
        end
    end

    // Control and output registers
    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            r_cal_cnt   <= '0;
            r_calib     <= 1'b0;
            r_stall_cnt <= '0;
            r_fifo_wptr <= 1'b0;
            r_fifo_rptr <= 1'b0;
            r_fifo_cnt  <= 2'd0;
            r_wcmd_vld  <= 1'b0;
            r_wcmd_idx  <= '0;
            r_rd_out    <= 3'd0;
            r_rd_vld    <= '0;
            r_app_rdy   <= 1'b0;
            r_wdf_rdy   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_cal_cnt   <= w_cal_cnt_nxt;
            r_calib     <= w_calib_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            if (w_push)   r_fifo_wptr <= ~r_fifo_wptr;
            if (w_commit) r_fifo_rptr <= ~r_fifo_rptr;
            r_fifo_cnt  <= w_fifo_cnt_nxt;
            r_wcmd_vld  <= w_wcmd_vld_nxt;
            if (w_wr_acc) r_wcmd_idx <= w_addr_idx;
            r_rd_out    <= w_rd_out_nxt;
            r_rd_vld    <= {r_rd_vld[READ_LATENCY-2:0], w_rd_acc};
            r_app_rdy   <= w_calib_nxt & ~w_stall_nxt & ~w_wcmd_vld_nxt & (w_rd_out_nxt < MAX_OUT);
            r_wdf_rdy   <= w_calib_nxt & (w_fifo_cnt_nxt < 2'd2);
            r_rd_valid  <= r_rd_vld[READ_LATENCY-1];
            if (r_rd_vld[READ_LATENCY-1]) r_rd_data <= r_rd_pipe[READ_LATENCY-1];
            r_cmd_err   <= r_cmd_err | w_ill_acc | (w_push & ~app_wdf_end);
        end
    end

    // Storage: array, write-data FIFO payload, read data pipeline (contents survive reset)
    always_ff @(posedge ui_clk) begin
        if (w_commit) r_mem[r_wcmd_idx] <= w_merged;
        if (w_push) begin
            r_fifo_data[r_fifo_wptr] <= app_wdf_data;
            r_fifo_mask[r_fifo_wptr] <= app_wdf_mask;
        end
        if (w_rd_acc) r_rd_pipe[0] <= w_rd_word;
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_rd_pipe[i] <= r_rd_pipe[i-1];
        end
    end

    assign app_rd_data         = r_rd_data;
    assign app_rd_data_valid   = r_rd_valid;
    assign app_rd_data_end     = r_rd_valid;
    assign app_rdy             = r_app_rdy;
    assign app_wdf_rdy         = r_wdf_rdy;
    assign init_calib_complete = r_calib;
    assign cmd_err             = r_cmd_err;

endmodule

// File: tb/tb_mig_app_responder.sv
// Scoreboard bench for mig_app_responder: stimulus pushes expected read returns (data, due cycle),
// a negedge monitor pops and compares whenever app_rd_data_valid is high.
module tb_mig_app_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic [127:0] app_wdf_data;
    logic         app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic [127:0] app_rd_data;
    logic         app_rd_data_end;
    logic         app_rd_data_valid;
    logic         app_rdy;
    logic         app_wdf_rdy;
    logic         init_calib_complete;
    logic         cmd_err;

    mig_app_responder #(
        .ADDR_WIDTH(27), .DEPTH_LOG2(10), .CALIB_CYCLES(16), .READ_LATENCY(4), .RDY_STALL_EVERY(0)
    ) dut (
        .ui_clk(clk), .ui_rst_n(rst_n),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
        .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
        .app_rd_data_valid(app_rd_data_valid), .app_rdy(app_rdy),
        .app_wdf_rdy(app_wdf_rdy), .init_calib_complete(init_calib_complete),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [127:0] d;
        int           due;
    } exp_t;
    exp_t exp_q[$];
    exp_t m_e;

    localparam logic [127:0] D2  = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] D3A = 128'hAAAAAAAAAAAAAAAA_AAAAAAAAAAAAAAAA;
    localparam logic [127:0] D3B = 128'h5555555555555555_5555555555555555;
    localparam logic [127:0] D3R = 128'hAAAAAAAAAAAAAAAA_5555555555555555;
    localparam logic [127:0] D4A = 128'hdeadbeef_00000001_cafef00d_00000002;
    localparam logic [127:0] D4B = 128'h13579bdf_2468ace0_0f1e2d3c_4b5a6978;
    localparam logic [127:0] D5 [5] = '{
        128'h11111111_11111111_11111111_11111111,
        128'h22222222_22222222_22222222_22222222,
        128'h33333333_33333333_33333333_33333333,
        128'h44444444_44444444_44444444_44444444,
        128'h55555555_66666666_77777777_88888888
    };

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic fail_bound(input string nm);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got no handshake, want handshake within bound (cycle %0d)", nm, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every returned read against the scoreboard
    always @(negedge clk) begin
        if (rst_n && app_rd_data_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_valid: got valid data %h, want no valid (cycle %0d)", app_rd_data, cyc);
            end else begin
                m_e = exp_q.pop_front();
                chk("rd_data", app_rd_data, m_e.d);
                chk("rd_due_cycle", 128'(cyc), 128'(m_e.due));
                chk("rd_data_end", 128'(app_rd_data_end), 128'd1);
            end
        end
    end

    // Write command and data presented together; each dropped once accepted
    task automatic wr(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m);
        logic cdone, ddone, ca, da;
        int n;
        app_addr = a; app_cmd = 3'b000; app_en = 1'b1;
        app_wdf_data = d; app_wdf_mask = m; app_wdf_end = 1'b1; app_wdf_wren = 1'b1;
        cdone = 1'b0; ddone = 1'b0; n = 0;
        while (!(cdone && ddone) && n < 40) begin
            ca = app_en & app_rdy;
            da = app_wdf_wren & app_wdf_rdy;
            step();
            n++;
            if (ca) begin cdone = 1'b1; app_en = 1'b0; end
            if (da) begin ddone = 1'b1; app_wdf_wren = 1'b0; end
        end
        if (!(cdone && ddone)) fail_bound("wr_handshake");
        app_en = 1'b0;
        app_wdf_wren = 1'b0;
    endtask

    task automatic issue_cmd(input logic [2:0] c, input logic [26:0] a);
        logic ok;
        int n;
        app_addr = a; app_cmd = c; app_en = 1'b1; ok = 1'b0; n = 0;
        while (!ok && n < 40) begin
            ok = app_rdy;
            step();
            n++;
        end
        if (!ok) fail_bound("cmd_handshake");
        app_en = 1'b0;
    endtask

    task automatic issue_data(input logic [127:0] d, input logic [15:0] m);
        logic ok;
        int n;
        app_wdf_data = d; app_wdf_mask = m; app_wdf_end = 1'b1; app_wdf_wren = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 40) begin
            ok = app_wdf_rdy;
            step();
            n++;
        end
        if (!ok) fail_bound("wdf_handshake");
        app_wdf_wren = 1'b0;
    endtask

    // Read: leaves app_en high so consecutive calls issue back-to-back
    task automatic rd(input logic [26:0] a, input logic [127:0] want, output int acc);
        logic ok;
        int n;
        app_addr = a; app_cmd = 3'b001; app_en = 1'b1; ok = 1'b0; n = 0; acc = -1;
        while (!ok && n < 40) begin
            ok = app_rdy;
            step();
            n++;
        end
        if (ok) begin
            acc = cyc;
            exp_q.push_back('{d: want, due: cyc + 4});
        end else begin
            fail_bound("rd_handshake");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) fail_bound("rd_drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int accs [5];

        // Reset and calibration; a read held on app_en must be ignored
        app_addr = 27'h40; app_cmd = 3'b001; app_en = 1'b1;
        app_wdf_data = '0; app_wdf_end = 1'b0; app_wdf_mask = '0; app_wdf_wren = 1'b0;
        repeat (3) step();
        chk("rst_app_rdy", 128'(app_rdy), 128'd0);
        chk("rst_wdf_rdy", 128'(app_wdf_rdy), 128'd0);
        chk("rst_calib", 128'(init_calib_complete), 128'd0);
        chk("rst_valid", 128'(app_rd_data_valid), 128'd0);
        chk("rst_end", 128'(app_rd_data_end), 128'd0);
        chk("rst_cmd_err", 128'(cmd_err), 128'd0);
        chk("rst_rd_data", app_rd_data, 128'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("calib_edge", 128'(init_calib_complete), 128'(k >= 16));
            chk("app_rdy_calib", 128'(app_rdy), 128'(k >= 16));
            if (k == 16) begin
                chk("wdf_rdy_calib", 128'(app_wdf_rdy), 128'd1);
                app_en = 1'b0;
            end
        end

        // Write with data in the same cycle, then read back
        wr(27'h40, D2, 16'h0000);
        rd(27'h40, D2, acc);
        app_en = 1'b0;
        drain();

        // Masked write: upper 8 bytes kept
        wr(27'h80, D3A, 16'h0000);
        wr(27'h80, D3B, 16'hFF00);
        rd(27'h80, D3R, acc);
        app_en = 1'b0;
        drain();

        // Write data 5 cycles after its command: command path stalls meanwhile
        issue_cmd(3'b000, 27'hC0);
        for (int i = 0; i < 5; i++) begin
            chk("rdy_wait_data", 128'(app_rdy), 128'd0);
            step();
        end
        issue_data(D4A, 16'h0000);
        rd(27'hC0, D4A, acc);
        app_en = 1'b0;
        drain();

        // Write data 2 cycles ahead of its command: commit follows the command
        issue_data(D4B, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            chk("wdf_rdy_early", 128'(app_wdf_rdy), 128'd1);
            step();
        end
        issue_cmd(3'b000, 27'hD0);
        chk("rdy_commit_pending", 128'(app_rdy), 128'd0);
        step();
        chk("rdy_after_commit", 128'(app_rdy), 128'd1);
        rd(27'hD0, D4B, acc);
        app_en = 1'b0;
        drain();

        // Five back-to-back reads: ready drops after the fourth until the first return
        for (int i = 0; i < 5; i++) wr(27'(32'h100 + 32'(i) * 32'h10), D5[i], 16'h0000);
        for (int i = 0; i < 5; i++) begin
            rd(27'(32'h100 + 32'(i) * 32'h10), D5[i], accs[i]);
            if (i == 3) chk("rdy_max_outstanding", 128'(app_rdy), 128'd0);
        end
        app_en = 1'b0;
        chk("b2b_acc1", 128'(accs[1] - accs[0]), 128'd1);
        chk("b2b_acc2", 128'(accs[2] - accs[0]), 128'd2);
        chk("b2b_acc3", 128'(accs[3] - accs[0]), 128'd3);
        chk("b2b_acc4", 128'(accs[4] - accs[0]), 128'd5);
        drain();

        // Reset with two reads in flight: nothing returns, array keeps its data
        rd(27'h40, D2, acc);
        rd(27'h80, D3R, acc);
        app_en = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        step();
        chk("midrst_valid", 128'(app_rd_data_valid), 128'd0);
        chk("midrst_rdy", 128'(app_rdy), 128'd0);
        chk("midrst_calib", 128'(init_calib_complete), 128'd0);
        step();
        rst_n = 1'b1;
        repeat (15) step();
        chk("recal_before", 128'(init_calib_complete), 128'd0);
        step();
        chk("recal_done", 128'(init_calib_complete), 128'd1);
        rd(27'h40, D2, acc);
        app_en = 1'b0;
        drain();

        // Illegal command: accepted, flags cmd_err, produces no read
        chk("cmd_err_clear", 128'(cmd_err), 128'd0);
        issue_cmd(3'b010, 27'h40);
        chk("cmd_err_set", 128'(cmd_err), 128'd1);
        step();
        chk("cmd_err_sticky", 128'(cmd_err), 128'd1);
        chk("rdy_after_illegal", 128'(app_rdy), 128'd1);
        repeat (8) step();
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
